// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory stage types, states and funct3 codes
// Purpose: shared types for mem_stage, lsu_align and the dmem interface.
package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] opr_res;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic        ld;
    logic        st;
    logic [2:0]  funct3;
  } mem_stage_in_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Access size is carried by funct3[1:0]: 00 byte, 01 half, else word.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] a);
    return ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

endpackage

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - writeback stage input record
// Purpose: record handed from the memory stage to writeback.
package wb_stage_pkg;

  typedef struct packed {
    logic [31:0] opr_res;              // ALU result / effective address
    logic [31:0] lsu_rdata;            // aligned, extended load data
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic [3:0]  mask;                 // issued byte-lane mask
    logic [31:0] core_out_mem_addr_in; // issued full byte address
    logic [31:0] core_out_mem_data_in; // issued lane-replicated wdata
  } wb_stage_in_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/grant/response port
// Purpose: bundles the dmem port.
// master: stage side (drives req/we/addr/wdata/mask, receives gnt/rvalid/rdata)
// slave : memory side
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - store lane mask/data and load extraction
// Purpose: combinational alignment helper for mem_stage.
// Ports: st_size/st_a/st_data -> st_mask/st_wdata (store side);
//        ld_funct3/ld_a/rdata -> ld_data (load side).
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_a,
  input  logic [31:0] st_data,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_a,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      2'b00: begin
        st_mask  = 4'b0001 << st_a;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        // Half accesses ignore a[0]; they land on lane 0 or 2.
        st_mask  = 4'b0011 << {st_a[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sh = rdata >> {ld_a, 3'b000};
  assign half_sh = rdata >> {ld_a[1], 4'b0000};

  always_comb begin
    case (ld_funct3)
      LSU_B:   ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LSU_H:   ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      LSU_BU:  ld_data = {24'd0, byte_sh[7:0]};
      LSU_HU:  ld_data = {16'd0, half_sh[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage between execute and writeback
// Purpose: accepts one execute result, runs a dmem req/gnt/rvalid
// transaction for loads/stores and registers the writeback record.
// Ports: clk, rst_n (sync, active-low); mem_in/in_valid/stall_o from
// execute; mem_out/out_valid to writeback; dmem (mem_stage_if.master);
// misalign_o only when MEM_MISALIGN_TRAP_EN is defined.
module mem_stage
  import mem_stage_pkg::*;
  import wb_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  mem_stage_in_t mem_in,
  input  logic          in_valid,
  output logic          stall_o,
  output wb_stage_in_t  mem_out,
  output logic          out_valid,
  mem_stage_if.master   dmem
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic          misalign_o
`endif
);

  state_t       state;
  wb_stage_in_t out_q;
  wb_stage_in_t pend_q;   // writeback record prepared at request time
  logic         pend_st;
  logic [2:0]   pend_funct3;
  logic         misalign_q;

  logic [3:0]   st_mask;
  logic [31:0]  st_wdata;
  logic [31:0]  ld_data;

  lsu_align u_align (
    .st_size   (mem_in.funct3[1:0]),
    .st_a      (mem_in.opr_res[1:0]),
    .st_data   (mem_in.rs2_data),
    .st_mask   (st_mask),
    .st_wdata  (st_wdata),
    .ld_funct3 (pend_funct3),
    .ld_a      (pend_q.core_out_mem_addr_in[1:0]),
    .rdata     (dmem.dmem_rdata),
    .ld_data   (ld_data)
  );

  function automatic wb_stage_in_t base_rec(mem_stage_in_t i);
    wb_stage_in_t r;
    r         = '0;
    r.opr_res = i.opr_res;
    r.pc4     = i.pc4;
    r.rd      = i.rd;
    r.rf_en   = i.rf_en;
    r.wb_sel  = i.wb_sel;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      out_q           <= '0;
      out_valid       <= 1'b0;
      pend_q          <= '0;
      pend_st         <= 1'b0;
      pend_funct3     <= 3'b000;
      misalign_q      <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_mask  <= '0;
    end else begin
      out_valid  <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (mem_in.ld || mem_in.st) begin
`ifdef MEM_MISALIGN_TRAP_EN
              if (is_misaligned(mem_in.funct3[1:0], mem_in.opr_res[1:0])) begin
                out_q                      <= base_rec(mem_in);
                out_q.rf_en                <= 1'b0;
                out_q.core_out_mem_addr_in <= mem_in.opr_res;
                out_valid                  <= 1'b1;
                misalign_q                 <= 1'b1;
              end else
`endif
              begin
                pend_q                      <= base_rec(mem_in);
                pend_q.mask                 <= st_mask;
                pend_q.core_out_mem_addr_in <= mem_in.opr_res;
                pend_q.core_out_mem_data_in <= st_wdata;
                pend_st                     <= mem_in.st;
                pend_funct3                 <= mem_in.funct3;
                dmem.dmem_req               <= 1'b1;
                dmem.dmem_we                <= mem_in.st;
                dmem.dmem_addr              <= {mem_in.opr_res[31:2], 2'b00};
                dmem.dmem_wdata             <= st_wdata;
                dmem.dmem_mask              <= st_mask;
                state                       <= S_REQ;
              end
            end else begin
              out_q     <= base_rec(mem_in);
              out_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            if (pend_st) begin
              out_q     <= pend_q;
              out_valid <= 1'b1;
              state     <= S_IDLE;
            end else if (dmem.dmem_rvalid) begin
              out_q           <= pend_q;
              out_q.lsu_rdata <= ld_data;
              out_valid       <= 1'b1;
              state           <= S_IDLE;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (dmem.dmem_rvalid) begin
            out_q           <= pend_q;
            out_q.lsu_rdata <= ld_data;
            out_valid       <= 1'b1;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_o = (state != S_IDLE);

  // Writeback must never act on a held, stale record.
  always_comb begin
    mem_out       = out_q;
    mem_out.rf_en = out_q.rf_en & out_valid;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;
  import wb_stage_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  mem_stage_in_t mem_in;
  logic          in_valid;
  logic          stall_o;
  wb_stage_in_t  mem_out;
  logic          out_valid;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          misalign_o;
`endif
  mem_stage_if   dmem ();

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_in    (mem_in),
    .in_valid  (in_valid),
    .stall_o   (stall_o),
    .mem_out   (mem_out),
    .out_valid (out_valid),
    .dmem      (dmem.master)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned size_of(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int unsigned lane_of(logic [2:0] f3, logic [31:0] addr);
    int unsigned a = addr % 4;
    case (size_of(f3))
      1:       return a;
      2:       return (a / 2) * 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_mask(logic [2:0] f3, logic [31:0] addr);
    int unsigned m = ((1 << size_of(f3)) - 1) << lane_of(f3, addr);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] rs2);
    case (size_of(f3))
      1:       return (rs2 & 32'hFF) * 32'h0101_0101;
      2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
    int unsigned sz = size_of(f3);
    int unsigned ln = lane_of(f3, addr);
    longint v;
    v = longint'(rdata >> (8 * ln)) & ((longint'(1) << (8 * sz)) - 1);
    if (sz < 4 && !f3[2] && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic wb_stage_in_t exp_out(mem_stage_in_t i, logic [31:0] rdata);
    wb_stage_in_t e = '0;
    e.opr_res = i.opr_res;
    e.pc4     = i.pc4;
    e.rd      = i.rd;
    e.rf_en   = i.rf_en;
    e.wb_sel  = i.wb_sel;
    if (i.ld || i.st) begin
      e.mask                 = exp_mask(i.funct3, i.opr_res);
      e.core_out_mem_addr_in = i.opr_res;
      e.core_out_mem_data_in = exp_wdata(i.funct3, i.rs2_data);
    end
    if (i.ld && !i.st) e.lsu_rdata = exp_load(i.funct3, i.opr_res, rdata);
    return e;
  endfunction

  function automatic mem_stage_in_t rand_in(bit ld, bit st, logic [2:0] f3);
    mem_stage_in_t r;
    r.opr_res  = $urandom;
    r.rs2_data = $urandom;
    r.rd       = 5'($urandom);
    r.pc4      = $urandom;
    r.rf_en    = 1'($urandom);
    r.wb_sel   = 2'($urandom);
    r.ld       = ld;
    r.st       = st;
    r.funct3   = f3;
    return r;
  endfunction

  // Issue one instruction; memory grants after gd wait cycles and,
  // for loads, returns data rd_dly cycles after the grant (0 = same cycle).
  task automatic run_op(input mem_stage_in_t i, input int gd, input int rd_dly,
                        input logic [31:0] rdata, input string tag,
                        output wb_stage_in_t got);
    wb_stage_in_t e;
    bit is_mem, is_ld;
    logic [31:0] ea;
    is_mem = i.ld || i.st;
    is_ld  = i.ld && !i.st;
    e      = exp_out(i, rdata);
    ea     = i.opr_res & 32'hFFFF_FFFC;
    dmem.dmem_rdata = ~rdata;
    mem_in   = i;
    in_valid = 1'b1;
    n_tests++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept_stall: got %b expected 0", tag, stall_o);
    end
    tick();
    in_valid = 1'b0;
    mem_in   = rand_in(1'b1, 1'b1, 3'($urandom));
    if (is_mem) begin
      for (int k = 0; k <= gd; k++) begin
        n_tests++;
        if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_mask, dmem.dmem_wdata, stall_o, out_valid}
            !== {1'b1, i.st, ea, e.mask, e.core_out_mem_data_in, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL %s req_cycle%0d: got req=%b we=%b addr=%h mask=%b wdata=%h stall=%b ov=%b expected req=1 we=%b addr=%h mask=%b wdata=%h stall=1 ov=0",
                   tag, k, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_mask, dmem.dmem_wdata,
                   stall_o, out_valid, i.st, ea, e.mask, e.core_out_mem_data_in);
        end
        if (k == gd) begin
          dmem.dmem_gnt = 1'b1;
          if (is_ld && rd_dly == 0) begin
            dmem.dmem_rvalid = 1'b1;
            dmem.dmem_rdata  = rdata;
          end
        end
        tick();
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = ~rdata;
      end
      if (is_ld) begin
        for (int k = 1; k <= rd_dly; k++) begin
          n_tests++;
          if ({dmem.dmem_req, stall_o, out_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s resp_cycle%0d: got req=%b stall=%b ov=%b expected req=0 stall=1 ov=0",
                     tag, k, dmem.dmem_req, stall_o, out_valid);
          end
          if (k == rd_dly) begin
            dmem.dmem_rvalid = 1'b1;
            dmem.dmem_rdata  = rdata;
          end
          tick();
          dmem.dmem_rvalid = 1'b0;
          dmem.dmem_rdata  = ~rdata;
        end
      end
    end
    got = mem_out;
    n_tests++;
    if (out_valid !== 1'b1 || mem_out !== e || stall_o !== 1'b0 || dmem.dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got ov=%b stall=%b req=%b out=%h expected ov=1 stall=0 req=0 out=%h",
               tag, out_valid, stall_o, dmem.dmem_req, mem_out, e);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || mem_out.rf_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse_end: got ov=%b rf_en=%b expected 0 0", tag, out_valid, mem_out.rf_en);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_tests++;
    if ({out_valid, stall_o, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_mask} !== '0
        || mem_out !== '0) begin
      n_fail++;
      $display("FAIL %s: got ov=%b stall=%b req=%b we=%b addr=%h wdata=%h mask=%b out=%h expected all zero",
               tag, out_valid, stall_o, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata,
               dmem.dmem_mask, mem_out);
    end
`ifdef MEM_MISALIGN_TRAP_EN
    n_tests++;
    if (misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s misalign: got %b expected 0", tag, misalign_o);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    mem_in = '0;
    dmem.dmem_gnt = 1'b0;
    dmem.dmem_rvalid = 1'b0;
    dmem.dmem_rdata = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    mem_stage_in_t i;
    wb_stage_in_t got;
    i = rand_in(1'b0, 1'b0, LSU_W);
    i.opr_res = 32'h1234;
    i.rd = 5'd5;
    i.rf_en = 1'b1;
    run_op(i, 0, 0, 32'h0, "alu", got);
    n_tests++;
    if (got.opr_res !== 32'h1234 || got.rd !== 5'd5 || got.rf_en !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_fields: got opr=%h rd=%0d rf_en=%b expected 1234 5 1", got.opr_res, got.rd, got.rf_en);
    end
  endtask

  task automatic test_store_byte();
    mem_stage_in_t i;
    wb_stage_in_t got;
    i = rand_in(1'b0, 1'b1, LSU_B);
    i.opr_res = 32'h1003;
    i.rs2_data = 32'h0000_00AB;
    run_op(i, 0, 0, 32'h0, "sb", got);
    n_tests++;
    if (got.mask !== 4'b1000 || got.core_out_mem_data_in !== 32'hABAB_ABAB) begin
      n_fail++;
      $display("FAIL sb_lanes: got mask=%b wdata=%h expected 1000 abababab", got.mask, got.core_out_mem_data_in);
    end
  endtask

  task automatic test_load_half();
    mem_stage_in_t i;
    wb_stage_in_t got;
    i = rand_in(1'b1, 1'b0, LSU_H);
    i.opr_res = 32'h2002;
    run_op(i, 2, 1, 32'h8001_0000, "lh", got);
    n_tests++;
    if (got.lsu_rdata !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL lh_data: got %h expected ffff8001", got.lsu_rdata);
    end
    tick();
    i.funct3 = LSU_HU;
    run_op(i, 2, 1, 32'h8001_0000, "lhu", got);
    n_tests++;
    if (got.lsu_rdata !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lhu_data: got %h expected 00008001", got.lsu_rdata);
    end
    tick();
  endtask

  task automatic test_load_same_cycle();
    mem_stage_in_t i;
    wb_stage_in_t got;
    logic [31:0] rd;
    i = rand_in(1'b1, 1'b0, LSU_W);
    i.opr_res = 32'h0000_4008;
    rd = $urandom;
    run_op(i, 0, 0, rd, "lw_same", got);
    n_tests++;
    if (got.lsu_rdata !== rd) begin
      n_fail++;
      $display("FAIL lw_same_data: got %h expected %h", got.lsu_rdata, rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_stage_in_t i;
    wb_stage_in_t e;
    for (int k = 0; k < 6; k++) begin
      i = rand_in(1'b0, 1'b0, 3'($urandom));
      e = exp_out(i, 32'h0);
      mem_in = i;
      in_valid = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || stall_o !== 1'b0 || mem_out !== e) begin
        n_fail++;
        $display("FAIL b2b_%0d: got ov=%b stall=%b out=%h expected ov=1 stall=0 out=%h",
                 k, out_valid, stall_o, mem_out, e);
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got ov=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    mem_stage_in_t i;
    wb_stage_in_t got;
    int kind;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      i = rand_in(kind == 1, kind == 2, 3'($urandom));
      if (kind == 2) i.funct3 = {1'b0, 2'($urandom_range(0, 2))};
`ifdef MEM_MISALIGN_TRAP_EN
      if (size_of(i.funct3) == 2) i.opr_res[0] = 1'b0;
      if (size_of(i.funct3) == 4) i.opr_res[1:0] = 2'b00;
`endif
      run_op(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", k), got);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset_midflight();
    mem_stage_in_t i;
    i = rand_in(1'b1, 1'b0, LSU_W);
    mem_in = i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dmem.dmem_gnt = 1'b1;
    tick();
    dmem.dmem_gnt = 1'b0;
    n_tests++;
    if (stall_o !== 1'b1 || dmem.dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_resp: got stall=%b req=%b expected 1 0", stall_o, dmem.dmem_req);
    end
    rst_n = 1'b0;
    tick();
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata = $urandom;
    tick();
    dmem.dmem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (out_valid !== 1'b0 || stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_late_rvalid%0d: got ov=%b stall=%b expected 0 0", k, out_valid, stall_o);
      end
      tick();
    end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    mem_stage_in_t i;
    i = rand_in(1'b1, 1'b0, LSU_W);
    i.opr_res = 32'h3001;
    i.rf_en = 1'b1;
    mem_in = i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({dmem.dmem_req, out_valid, misalign_o, mem_out.rf_en, mem_out.mask, stall_o} !== {3'b011, 1'b0, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL misalign_lw: got req=%b ov=%b mis=%b rf_en=%b mask=%b stall=%b expected 0 1 1 0 0000 0",
               dmem.dmem_req, out_valid, misalign_o, mem_out.rf_en, mem_out.mask, stall_o);
    end
    tick();
    n_tests++;
    if ({dmem.dmem_req, out_valid, misalign_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL misalign_end: got req=%b ov=%b mis=%b expected 000", dmem.dmem_req, out_valid, misalign_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store_byte();
    test_load_half();
    test_load_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage core, between execute and writeback. Latches one execute result per accepted instruction and, for loads and stores, runs a request/grant/response transaction on the data-memory port. Produces a registered `wb_stage_in_t` for writeback: byte-lane store mask and data, and aligned, sign- or zero-extended load data. Stalls upstream for the duration of any memory transaction.

## Interface

Parameters:
- none; all widths are fixed at 32-bit RV32.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset.
- `mem_in` in `mem_stage_in_t`: execute result. Fields: `opr_res` (ALU result / effective address), `rs2_data`, `rd`, `pc4`, `rf_en`, `wb_sel[1:0]`, `ld`, `st`, `funct3[2:0]`.
- `in_valid` in 1: `mem_in` holds a real instruction.
- `stall_o` out 1: upstream must hold; input is accepted only when `in_valid && !stall_o`.
- `mem_out` out `wb_stage_in_t`: registered result to writeback.
- `out_valid` out 1: `mem_out` is valid. High for exactly 1 cycle per instruction.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word address, with `[1:0]` forced to 0.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_mask` out 4: byte-lane enables.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data.
- `misalign_o` out 1: present only with the `_EN` macro (see Configuration).

## Operation

State machine:
- States: IDLE, REQ, RESP.
- IDLE, accepted input with `ld|st` set:
  - Latch address, mask, wdata and control into request registers.
  - Next state REQ.
- IDLE, accepted input with neither `ld` nor `st`:
  - Load output register next edge, `out_valid=1`, `lsu_rdata=0`.
  - Stay in IDLE.
- REQ:
  - `dmem_req=1`; address, mask, wdata and we held stable until `dmem_gnt`.
  - Store with `gnt`: complete, go to IDLE.
  - Load with `gnt` and no `rvalid`: go to RESP.
  - Load with `gnt` and `rvalid` in the same cycle: complete, go to IDLE.
- RESP:
  - `dmem_req=0`.
  - On `rvalid`: complete, go to IDLE.
- Completion loads the output register; `out_valid` rises the next cycle.

Stall and output rules:
- `stall_o = (state != IDLE)`, combinational. An input is never accepted on a completion cycle, so there is 1 bubble after each memory operation.
- `mem_out.rf_en` is driven as `rf_en & out_valid`. Writeback must never see a stale write.

Mask and store data (`a = opr_res[1:0]`):
- Byte: `mask = 4'b0001 << a`, `wdata = {4{rs2[7:0]}}`.
- Half: `mask = 4'b0011 << {a[1],1'b0}`, `wdata = {2{rs2[15:0]}}`.
- Word: `mask = 4'b1111`, `wdata = rs2`.

Load extraction from `dmem_rdata`, using the latched `a`:
- LB (000) and LH (001): sign-extended.
- LW (010).
- LBU (100) and LHU (101): zero-extended.
- Other `funct3` codes are treated as LW.

Pass-through fields:
- `mem_out.mask`, `core_out_mem_addr_in` and `core_out_mem_data_in` carry the issued mask, full byte address and wdata.
- These are zero for non-memory instructions.

## Timing

- Reset: state IDLE; `out_valid=0`, `mem_out=0`, `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`, `dmem_mask=0`, `stall_o=0`, `misalign_o=0`.
- Non-memory instruction: latency 1 cycle, throughput 1 per cycle.
- Store with grant on the first REQ cycle: `out_valid` 2 cycles after acceptance.
- Load with `gnt` and `rvalid` each 1 cycle later: `out_valid` 3 cycles after acceptance.
- Reset mid-transaction: `dmem_req` drops at the reset edge. An `rvalid` arriving later in IDLE is ignored.

## Configuration

- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with `a[0]=1`, or a word access with `a≠0`, issues no request.
  - It completes in IDLE with `rf_en=0`, `mask=0`, and a 1-cycle `misalign_o` pulse aligned with `out_valid`.
- Not defined:
  - No check and no `misalign_o` port.
  - Low address bits are ignored by size: word uses 0; half uses `{a[1],0}`.

## Structure

- `mem_stage_pkg` holds:
  - `mem_stage_in_t`.
  - The state enum.
  - `funct3` localparams: `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
- The output type is `wb_stage_in_t` from `wb_stage_pkg`.
- One sub-module, `lsu_align`: a combinational block for mask/wdata generation and load extraction. The FSM and registers live in `mem_stage`.

## Test plan

- ALU op, `opr_res=0x1234`, `rd=5`, `rf_en=1` → next cycle `out_valid=1`, `opr_res=0x1234`, `rf_en=1`, `stall_o` never high.
- SB at `0x1003` with `rs2=0xAB`, `gnt` on the first REQ cycle → `dmem_addr=0x1000`, `mask=1000`, `wdata=0xABABABAB`, `we=1`; `out_valid` 2 cycles after acceptance.
- LH at `0x2002`, `rdata=0x8001_0000`, `gnt` after 2 wait cycles, `rvalid` 1 later → `lsu_rdata=0xFFFF8001`; LHU gives `0x00008001`.
- LW with `gnt` and `rvalid` in the same cycle → completes from REQ, RESP is skipped, `lsu_rdata=rdata`.
- `rst_n` low during RESP → all outputs zero next cycle; a subsequent `rvalid` produces no `out_valid`.
- With `MEM_MISALIGN_TRAP_EN`: LW at `0x3001` → `dmem_req` never asserted; `misalign_o=1` and `rf_en=0` on the `out_valid` cycle.
